// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 4-stage vector pipeline: RAW scoreboard, branch hold, wrong-path flush.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / flush_count performance counter outputs.
module pipe_hazard_ctrl #(
   parameter int selectionBits = 4,
   parameter int pipeDepth     = 3,
   parameter int cntWidth      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dec_valid,
   input  logic [selectionBits-1:0] dec_rs1,
   input  logic                     dec_rs1_used,
   input  logic [selectionBits-1:0] dec_rs2,
   input  logic                     dec_rs2_used,
   input  logic [selectionBits-1:0] dec_rd,
   input  logic                     dec_wr,
   input  logic                     dec_branch,
   input  logic                     wb_valid,
   input  logic [selectionBits-1:0] wb_rd,
   input  logic                     wb_wr,
   input  logic                     wb_branch_done,
   input  logic                     wb_branch_taken,
   output logic                     issue,
   output logic                     stall,
   output logic                     bubble,
   output logic                     flush,
   output logic [1:0]               state,
   output logic                     sb_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [cntWidth-1:0]      stall_cycles,
   output logic [cntWidth-1:0]      flush_count
`endif
);

   localparam int NumRegs = 2 ** selectionBits;
   localparam int SbW     = $clog2(pipeDepth + 1);
   localparam logic [SbW-1:0] SbMax = SbW'(pipeDepth);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      BR_WAIT = 2'd1,
      FLUSH   = 2'd2
   } state_e;

   if (cntWidth < 1 || pipeDepth < 1) begin : g_bad_params
      $error("pipe_hazard_ctrl: cntWidth and pipeDepth must be at least 1");
   end

   state_e               state_q, state_d;
   logic [SbW-1:0]       cnt_q [NumRegs];
   logic [SbW-1:0]       cnt_d [NumRegs];
   logic                 sb_err_q, sb_err_d;
   logic [NumRegs-1:0]   inc_hit, dec_hit;
   logic                 hz, sb_evt, fsm_evt;

   // Counters are registered, so a write retiring this cycle releases its reader only next cycle.
   assign hz = (dec_rs1_used && cnt_q[dec_rs1] != '0) ||
               (dec_rs2_used && cnt_q[dec_rs2] != '0);

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      stall   = 1'b0;
      bubble  = 1'b0;
      flush   = 1'b0;
      fsm_evt = 1'b0;
      if (!rst) begin
         unique case (state_q)
            RUN: begin
               issue   = dec_valid && !hz;
               stall   = dec_valid && hz;
               bubble  = !issue;
               fsm_evt = wb_branch_done;
               if (issue && dec_branch) state_d = BR_WAIT;
            end
            BR_WAIT: begin
               stall  = 1'b1;
               bubble = 1'b1;
               if (wb_branch_done) state_d = wb_branch_taken ? FLUSH : RUN;
            end
            FLUSH: begin
               flush   = 1'b1;
               bubble  = 1'b1;
               fsm_evt = wb_branch_done;
               state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   assign inc_hit = (issue && dec_wr)    ? (NumRegs'(1) << dec_rd) : '0;
   assign dec_hit = (wb_valid && wb_wr)  ? (NumRegs'(1) << wb_rd)  : '0;

   always_comb begin
      sb_evt = 1'b0;
      for (int i = 0; i < NumRegs; i++) begin
         cnt_d[i] = cnt_q[i];
         if (inc_hit[i] && !dec_hit[i]) begin
            if (cnt_q[i] == SbMax) sb_evt = 1'b1;
            else                   cnt_d[i] = cnt_q[i] + SbW'(1);
         end else if (dec_hit[i] && !inc_hit[i]) begin
            if (cnt_q[i] == '0) sb_evt = 1'b1;
            else                cnt_d[i] = cnt_q[i] - SbW'(1);
         end
      end
      sb_err_d = sb_err_q || sb_evt || fsm_evt;
   end

   // NOTE: the scoreboard is a register array, not RAM, so it is reset like any other state;
   // sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= RUN;
         sb_err_q <= 1'b0;
         for (int i = 0; i < NumRegs; i++) cnt_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         sb_err_q <= sb_err_d;
         for (int i = 0; i < NumRegs; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign state  = state_q;
   assign sb_err = sb_err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [cntWidth-1:0] stall_cycles_q, stall_cycles_d;
   logic [cntWidth-1:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (stall && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + cntWidth'(1);
      if (flush && flush_count_q != '1)  flush_count_d  = flush_count_q + cntWidth'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule
